// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background SECDED scrubber that reads every word, writes back corrections and logs uncorrectable errors
module ecc_scrub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16,
    parameter int IVL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [IVL_W-1:0]  interval,
    input  logic              clr_cnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [12:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [12:0]       mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_irq,
    output logic              pass_done
);
    typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic [IVL_W-1:0] timer;
    logic [12:0] word;
    logic [12:0] fixed;
    logic [3:0] syn;
    logic pe, corr, uncorr;
    assign busy = state != IDLE;
    // syndrome over Hamming positions 1..12, overall parity, and the repaired word
    always_comb begin
        syn[0] = word[0] ^ word[2] ^ word[4] ^ word[6] ^ word[8] ^ word[10];
        syn[1] = word[1] ^ word[2] ^ word[5] ^ word[6] ^ word[9] ^ word[10];
        syn[2] = word[3] ^ word[4] ^ word[5] ^ word[6] ^ word[11];
        syn[3] = word[7] ^ word[8] ^ word[9] ^ word[10] ^ word[11];
        pe = ^word;
        corr = pe && syn <= 4'd12;
        uncorr = !corr && syn != 4'd0;
        fixed = syn == 4'd0 ? word ^ 13'h1000 : word ^ (13'd1 << (syn - 4'd1));
    end
    // scrub sequencer: wait interval, read, classify, optionally write back, advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            timer      <= '0;
            word       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            err_addr   <= '0;
            err_irq    <= 1'b0;
            pass_done  <= 1'b0;
        end else begin
            err_irq   <= 1'b0;
            pass_done <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    timer <= interval;
                    state <= WAIT;
                end
                WAIT: if (!en) state <= IDLE;
                else if (timer == '0) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= addr;
                    state    <= RD_REQ;
                end else timer <= timer - 1'b1;
                RD_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: if (mem_rvalid) begin
                    word  <= mem_rdata;
                    state <= CHECK;
                end
                CHECK: if (corr) begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= fixed;
                    state     <= WR_REQ;
                end else begin
                    if (uncorr) begin
                        err_addr <= addr;
                        err_irq  <= 1'b1;
                    end
                    state <= NEXT;
                end
                WR_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= NEXT;
                end
                NEXT: begin
                    addr      <= addr + 1'b1;
                    pass_done <= &addr;
                    timer     <= interval;
                    state     <= en ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (clr_cnt) begin
                corr_cnt   <= '0;
                uncorr_cnt <= '0;
            end else if (state == CHECK) begin
                if (corr && corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + 1'b1;
                if (uncorr && uncorr_cnt != CNT_MAX) uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrub controller for a memory array that stores 13-bit SECDED words. Each word is the 12-bit Hamming codeword from the team's encoder plus an overall parity bit.
- Walks every address, reads the word and computes syndrome and overall parity.
- Writes back corrected data for single-bit errors; logs uncorrectable errors.
- Shares the memory port with host traffic through an external req/gnt arbiter.

Parameters:
ADDR_W, 8, address width; scrub range is 0 .. 2^ADDR_W-1
CNT_W, 16, width of saturating error counters
IVL_W, 16, width of inter-word interval timer

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  scrub enable
interval  in  IVL_W  idle cycles between word scrubs (0 = back-to-back)
clr_cnt  in  1  clears corr_cnt/uncorr_cnt
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  access address
mem_wdata  out  13  write word
mem_gnt  in  1  arbiter grant; access accepted on cycle mem_req&mem_gnt
mem_rvalid  in  1  read data valid (>=1 cycle after accepted read)
mem_rdata  in  13  read word
busy  out  1  FSM not in IDLE
corr_cnt  out  CNT_W  corrected-error count, saturating
uncorr_cnt  out  CNT_W  uncorrectable-error count, saturating
err_addr  out  ADDR_W  address of most recent uncorrectable word
err_irq  out  1  1-cycle pulse per uncorrectable word
pass_done  out  1  1-cycle pulse when address wraps from max to 0

Behaviour:
- Reset: all outputs 0, FSM IDLE, address 0, timer 0.
- Word format: bits[11:0] = {d7,d6,d5,d4,p4,d3,d2,d1,p3,d0,p2,p1}. Hamming position k (1..12) is bit k-1. Bit12 = XOR of bits[11:0], giving even parity over 13 bits.
- Syndrome: s[i] = XOR of bits whose position has bit i set, i = 0..3. Parity error pe = XOR of all 13 bits.
- Classification:
  - s=0, pe=0: clean.
  - s=0, pe=1: bit12 error, correctable.
  - s in 1..12, pe=1: flip bit s-1, correctable.
  - s!=0, pe=0: double error, uncorrectable.
  - s in 13..15, pe=1: uncorrectable.
- States:
  - IDLE: if en, load timer=interval and go WAIT.
  - WAIT: decrement timer; at 0 go RD_REQ. If en=0, go IDLE.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=addr. Hold until gnt, then go RD_WAIT.
  - RD_WAIT: on mem_rvalid, capture rdata and go CHECK.
  - CHECK (1 cycle): classify.
    - Correctable: corr_cnt+1, go WR_REQ.
    - Uncorrectable: uncorr_cnt+1, err_addr=addr, err_irq=1, go NEXT.
    - Clean: go NEXT.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata=corrected word, same addr. Hold until gnt, then go NEXT.
  - NEXT: addr+1 (wraps mod 2^ADDR_W). pass_done=1 on wrap to 0. If en, reload timer and go WAIT; else go IDLE.
- Request signals: mem_req/we/addr/wdata registered and stable while mem_req=1 and no gnt. mem_req drops the cycle after acceptance. mem_gnt and mem_rvalid are ignored in other states.
- Latency with interval=0 and immediate gnt/rvalid:
  - Clean word: 5 cycles (WAIT→RD_REQ→RD_WAIT→CHECK→NEXT).
  - Correctable word: 6 cycles.
- en deassert mid-operation: the in-flight word completes, including write-back, then the FSM goes IDLE. The address is retained, so the next enable resumes at the next address.
- Counters saturate at 2^CNT_W-1. clr_cnt has priority over a same-cycle increment (result 0). err_addr is not cleared by clr_cnt.
- rst mid-operation: everything returns to reset values at the next edge, including mem_req=0. A pending read's rvalid is then ignored.

Test Plan:
- Clean word: memory all 0x0A27 (encoded 0xA5, parity 0), interval=0, en=1, gnt/rvalid immediate. Expect no writes, counters 0, and pass_done after 256 words; addresses read sequentially 0..255.
- Single bit: addr 3 = 0x0A07 (bit5 flipped, s=6). Expect a write of 0x0A27 to addr 3, corr_cnt=1, err_irq never asserted.
- Parity bit: addr 7 = 0x1A27. Expect a write of 0x0A27 to addr 7 and corr_cnt+1.
- Double error: addr 9 = 0x0A24 (bits 0,1 flipped). Expect no write, uncorr_cnt=1, err_addr=9, and exactly one err_irq pulse.
- Handshake: hold gnt=0 for 10 cycles during RD_REQ. Expect mem_req/addr stable for 10 cycles. rvalid delayed 4 cycles: the FSM waits in RD_WAIT.
- Control: drop en during WR_REQ; the write still completes, then busy=0 and addr advanced. Assert clr_cnt in the same cycle as a CHECK correction: corr_cnt=0. Assert rst during RD_WAIT: mem_req=0 and addr=0 the next cycle.
